// File: rtl/piso_tx_5bit.sv
// piso_tx_5bit: five-bit parallel-in/serial-out transmitter, LSB first.
// Words are accepted through a ready/load handshake and shifted out one bit
// per clock. Back-to-back frames have no gap when load is held high.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit, making
// six-bit frames. Undefined means plain five-bit frames.
module piso_tx_5bit (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] data_in,
    input  logic       load,
    output logic       ready,
    output logic       serial_out,
    output logic       bit_valid,
    output logic       done
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_BITS = 6;
`else
    localparam int FRAME_BITS = 5;
`endif
    localparam logic [2:0] LAST_CNT = 3'(FRAME_BITS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [FRAME_BITS-1:0]   sh;
    logic [2:0]              cnt;
    logic [FRAME_BITS-1:0]   load_word;
    logic                    last_bit;
    logic                    accept;

    // The parity bit sits above the data so that it leaves the wire last.
`ifdef PISO_PARITY_EN
    assign load_word = {^data_in, data_in};
`else
    assign load_word = data_in;
`endif

    // The last-bit cycle is the only point inside a frame where a new word may
    // be taken. ready is a pure state decode, so accept has no comb path back
    // into ready.
    assign last_bit = (state == SHIFT) && (cnt == LAST_CNT);
    assign accept   = load && ready;

    // State register; reset overrides load at the same edge.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: leave IDLE on an accepted load, and stay in SHIFT across a
    // frame boundary only when the next word is accepted on the last bit.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = accept ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: decoded from the registered state only.
    always_comb begin
        ready      = 1'b0;
        serial_out = 1'b0;
        bit_valid  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
            end
            SHIFT: begin
                serial_out = sh[0];
                bit_valid  = 1'b1;
                ready      = (cnt == LAST_CNT);
                done       = (cnt == LAST_CNT);
            end
            default: ;
        endcase
    end

    // Shift register and bit counter. A word is captured only on an accepted
    // load; otherwise SHIFT drains sh with zero fill. The counter is cleared
    // on the way back to IDLE so that every frame starts from a known count.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh  <= '0;
            cnt <= '0;
        end else if (accept) begin
            sh  <= load_word;
            cnt <= '0;
        end else if (state == SHIFT) begin
            sh <= {1'b0, sh[FRAME_BITS-1:1]};
            if (last_bit) cnt <= '0;
            else          cnt <= cnt + 3'd1;
        end
    end

endmodule

// File: tb/tb_piso_tx_5bit.sv
// Directed bench for piso_tx_5bit. A receive-side SIPO shadows the serial
// line so that frame reassembly can be checked as well as the raw bit stream.
module tb_piso_tx_5bit;

`ifdef PISO_PARITY_EN
    localparam int FB = 6;
`else
    localparam int FB = 5;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] data_in = '0;
    logic       load = 1'b0;
    logic       ready, serial_out, bit_valid, done;
    logic [4:0] sipo = '0;

    int total = 0;
    int bad   = 0;

    piso_tx_5bit dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .load       (load),
        .ready      (ready),
        .serial_out (serial_out),
        .bit_valid  (bit_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Receive register: LSB arrives first, so shift in from the top.
    always @(posedge clk) sipo <= {serial_out, sipo[4:1]};

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".rdy"}, ready, 1'b1);
        chk({tag, ".so"},  serial_out, 1'b0);
        chk({tag, ".bv"},  bit_valid, 1'b0);
        chk({tag, ".dn"},  done, 1'b0);
    endtask

    // Expected frame bit i for a given word: data LSB first, then even parity.
    function automatic logic fbit(input logic [4:0] w, input int i);
        if (i < 5) return w[i];
        return ^w;
    endfunction

    logic [9:0] b2b;

    initial begin
        // Reset and idle.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("rst");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle($sformatf("idle%0d", i));
        end

        // Single frame 10110: 0,1,1,0,1 then SIPO holds the word after N+5.
        data_in = 5'b10110;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        data_in = 5'b00000;
        for (int i = 0; i < FB; i++) begin
            chk($sformatf("f1.so%0d", i), serial_out, fbit(5'b10110, i));
            chk($sformatf("f1.bv%0d", i), bit_valid, 1'b1);
            chk($sformatf("f1.dn%0d", i), done, (i == FB - 1));
            chk($sformatf("f1.rd%0d", i), ready, (i == FB - 1));
            tick();
            if (i == 4) chk("f1.sipo", sipo, 5'b10110);
        end
        chk_idle("f1.end");

        // Back-to-back 00001 then 11110 with load held high.
        b2b     = 10'b1111000001;
        data_in = 5'b00001;
        load    = 1'b1;
        tick();
        data_in = 5'b11110;
        for (int i = 0; i < 2 * FB; i++) begin
            chk($sformatf("bb.so%0d", i), serial_out,
                (i < FB) ? fbit(5'b00001, i) : fbit(5'b11110, i - FB));
            chk($sformatf("bb.bv%0d", i), bit_valid, 1'b1);
            chk($sformatf("bb.dn%0d", i), done, (i == FB - 1) || (i == 2 * FB - 1));
`ifndef PISO_PARITY_EN
            chk($sformatf("bb.lit%0d", i), serial_out, b2b[i]);
`endif
            tick();
            if (i == FB - 1) load = 1'b0;
        end
        chk_idle("bb.end");

        // Load during bit 2 of an all-zero frame is ignored.
        data_in = 5'b00000;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        for (int i = 0; i < FB; i++) begin
            if (i == 2) begin
                data_in = 5'b11111;
                load    = 1'b1;
                chk("ig.rd2", ready, 1'b0);
            end
            chk($sformatf("ig.so%0d", i), serial_out, 1'b0);
            chk($sformatf("ig.bv%0d", i), bit_valid, 1'b1);
            chk($sformatf("ig.dn%0d", i), done, (i == FB - 1));
            tick();
            load = 1'b0;
        end
        chk_idle("ig.end");

        // Reset after bit 2 aborts the frame with no done.
        data_in = 5'b11111;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ab.so%0d", i), serial_out, 1'b1);
            chk($sformatf("ab.dn%0d", i), done, 1'b0);
            if (i == 2) reset = 1'b1;
            tick();
        end
        reset = 1'b0;
        chk_idle("ab.r0");
        tick();
        chk_idle("ab.r1");

        // Reset wins over load at the same edge.
        data_in = 5'b11111;
        load    = 1'b1;
        reset   = 1'b1;
        tick();
        load    = 1'b0;
        reset   = 1'b0;
        chk_idle("rp");

`ifdef PISO_PARITY_EN
        // Parity frames with literal expectations.
        begin
            logic [5:0] e1, e2;
            e1 = 6'b110110;
            e2 = 6'b000011;
            data_in = 5'b10110;
            load    = 1'b1;
            tick();
            load = 1'b0;
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("p1.so%0d", i), serial_out, e1[i]);
                chk($sformatf("p1.dn%0d", i), done, (i == 5));
                tick();
            end
            data_in = 5'b00011;
            load    = 1'b1;
            tick();
            load = 1'b0;
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("p2.so%0d", i), serial_out, e2[i]);
                chk($sformatf("p2.dn%0d", i), done, (i == 5));
                tick();
            end
            chk_idle("p.end");
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piso_tx_5bit.md
# piso_tx_5bit

Five-bit parallel-in/serial-out transmitter, the send-side counterpart of the 5-bit SIPO receive register. It accepts a 5-bit word through a ready/load handshake and shifts it out one bit per clock, LSB first. A 5-bit SIPO clocked on the same edge holds the original word, bit-for-bit, after the fifth bit is sampled. It sits between the word-producing control logic and the single-wire serial link.

## Interface

- No parameters; the word width is fixed at 5 bits.
- `clk`  input  1  single system clock; all state changes on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `data_in`  input  5  parallel word to transmit; sampled only on an accepted load.
- `load`  input  1  request to start transmitting `data_in`.
- `ready`  output  1  block can accept a load this cycle.
- `serial_out`  output  1  serial data line; low when idle.
- `bit_valid`  output  1  high while `serial_out` carries a data (or parity) bit.
- `done`  output  1  one-cycle pulse coincident with the last bit of a frame.

## Operation

- States: IDLE and SHIFT. Internal 5-bit shift register `sh`, 3-bit bit counter `cnt`.
- Reset (`reset`=1 at a rising edge): state=IDLE, `sh`=0, `cnt`=0. Outputs after reset: `ready`=1, `serial_out`=0, `bit_valid`=0, `done`=0.
- Accept: `load`=1 and `ready`=1 at a rising edge → `sh`←`data_in`, `cnt`←0, state←SHIFT.
- In SHIFT: `serial_out`=`sh[0]`, `bit_valid`=1. Each edge shifts `sh` right with zero fill and increments `cnt`.
- Last bit: `cnt`=4 (parity build: `cnt`=5). `done`=1 and `ready`=1 in that cycle.
- End of last bit: with an accepted `load`, the block reloads and stays in SHIFT (back-to-back, no gap). Without one, state→IDLE.
- `ready`=1 in IDLE and during the last-bit cycle only. A `load` at any other time is ignored and `data_in` is not sampled.
- IDLE: `serial_out`=0, `bit_valid`=0, `done`=0.
- Reset mid-frame aborts the frame immediately. No `done` is issued, and the partial frame is discarded.
- `reset` has priority over `load` at the same edge.

## Timing

- Load accepted at edge N → `serial_out`=`data_in[0]` after edge N, `data_in[1]` after N+1, and so on, with `data_in[4]` after N+4.
- A SIPO sampling `serial_out` at edges N+1..N+5 holds `out[4:0]`=`data_in` after edge N+5.
- Frame length is 5 cycles (6 with parity). Throughput is one word per 5 (6) cycles when `load` is held high.
- `ready` and `done` are registered-state decodes with no combinational path from `load`.
- Latency from load edge to first bit is 0 cycles: the first bit is valid in the cycle after the accepting edge.

## Configuration

- `PISO_PARITY_EN` defined: a 6th bit, even parity (XOR of `data_in[4:0]`) captured at load, is sent after `data_in[4]`. `bit_valid`=1 for 6 cycles, and `done` and `ready` assert on the parity cycle.
- `PISO_PARITY_EN` undefined: 5-bit frames exactly as above, with no parity logic.

## Test plan

- Reset, then idle 3 cycles → `ready`=1, `serial_out`=0, `bit_valid`=0, `done`=0 throughout.
- Load `5'b10110` at edge N → `serial_out` reads 0,1,1,0,1 after edges N..N+4. `done`=1 only after N+4. A paired SIPO reads `5'b10110` after N+5.
- `load` held high with `5'b00001` then `5'b11110` presented back-to-back → 10 contiguous valid bits 1,0,0,0,0,0,1,1,1,1 with no gap, and `done` pulses after N+4 and N+9.
- `load`=1 with `5'b11111` during bit 2 of a frame carrying `5'b00000` → ignored; the frame completes as all zeros and the block returns to IDLE.
- `reset` asserted after bit 2 of a frame → next cycle is IDLE, `serial_out`=0, `ready`=1, and no `done` pulse.
- With `PISO_PARITY_EN`, load `5'b10110` → 6 bits 0,1,1,0,1,1 (parity=1), with `done` on the 6th bit; load `5'b00011` → parity bit 0.
